// File: rtl/dekatron_pkg.sv
// dekatron_pkg
//   Shared definitions for the dekatron counter: one-hot position width and
//   constants, the ripple FSM state type, and the rotate helpers that move a
//   glow position one step up or down.
//   Ports: none (package).
//   Configuration: none here; see dekatron_counter for DEKATRON_ONEHOT_CHECK_EN.
package dekatron_pkg;

   localparam int POS_WIDTH = 10;
   localparam logic [POS_WIDTH-1:0] POS_ZERO = 10'b0000000001;
   localparam logic [POS_WIDTH-1:0] POS_NINE = 10'b1000000000;

   typedef enum logic {
      IDLE   = 1'b0,
      RIPPLE = 1'b1
   } state_t;

   // +1: glow moves to the next cathode, 9 rolls over to 0.
   function automatic logic [POS_WIDTH-1:0] rot_up(input logic [POS_WIDTH-1:0] p);
      return {p[POS_WIDTH-2:0], p[POS_WIDTH-1]};
   endfunction

   // -1: glow moves to the previous cathode, 0 rolls under to 9.
   function automatic logic [POS_WIDTH-1:0] rot_down(input logic [POS_WIDTH-1:0] p);
      return {p[0], p[POS_WIDTH-1:1]};
   endfunction

endpackage

// File: rtl/dekatron_digit.sv
// dekatron_digit
//   One decade stage: a 10-bit one-hot glow position that steps up or down.
//   Ports:
//     Clk    in   clock
//     Rst_n  in   asynchronous active-low reset (position -> 0)
//     Step   in   move the position one place this edge
//     Dec    in   direction of the step: 0 = up, 1 = down
//     Clear  in   force position 0 this edge (wins over Step)
//     Pos    out  registered one-hot position
//     Wrap   out  combinational; Step would cross the 9/0 boundary
module dekatron_digit
   import dekatron_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Step,
   input  logic                 Dec,
   input  logic                 Clear,
   output logic [POS_WIDTH-1:0] Pos,
   output logic                 Wrap
);

   logic [POS_WIDTH-1:0] pos_reg;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pos_reg <= POS_ZERO;
      end else if (Clear) begin
         pos_reg <= POS_ZERO;
      end else if (Step) begin
         pos_reg <= Dec ? rot_down(pos_reg) : rot_up(pos_reg);
      end
   end

   assign Wrap = Step & (Dec ? (pos_reg == POS_ZERO) : (pos_reg == POS_NINE));
   assign Pos  = pos_reg;

endmodule

// File: rtl/dekatron_counter.sv
// dekatron_counter
//   Multi-digit decimal up/down counter built from a chain of one-hot decade
//   stages. Digit 0 steps on the accepting edge; carries/borrows then ripple
//   one digit per clock while Ready is low.
//   Ports:
//     Clk      in   clock
//     Rst_n    in   asynchronous active-low reset
//     Request  in   step command, taken when Ready=1
//     Dec      in   direction of an accepted Request: 0 = +1, 1 = -1
//     Clear    in   synchronous clear-to-zero, taken when Ready=1, beats Request
//     Ready    out  registered; 1 = idle
//     Out      out  DIGITS*10 one-hot positions, digit d at Out[d*10 +: 10]
//     Zero     out  combinational; every digit at position 0
//     Carry    out  registered one-cycle pulse when the top digit wraps
//     Error    out  (DEKATRON_ONEHOT_CHECK_EN only) one-cycle pulse when a
//                   digit was found not one-hot and was repaired to 0
//   Configuration macro: DEKATRON_ONEHOT_CHECK_EN
module dekatron_counter
   import dekatron_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          Request,
   input  logic                          Dec,
   input  logic                          Clear,
   output logic                          Ready,
   output logic [DIGITS*POS_WIDTH-1:0]   Out,
   output logic                          Zero,
   output logic                          Carry
`ifdef DEKATRON_ONEHOT_CHECK_EN
   ,
   output logic                          Error
`endif
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic              dir_reg, dir_next;
   logic              ready_reg;
   logic              carry_reg, carry_next;

   logic [DIGITS-1:0] step;
   logic [DIGITS-1:0] digit_dec;
   logic [DIGITS-1:0] clr;
   logic [DIGITS-1:0] wrap;
   logic [DIGITS-1:0] is_zero;
   logic              clear_all;

`ifdef DEKATRON_ONEHOT_CHECK_EN
   logic [DIGITS-1:0] bad;
   logic              any_bad;
   logic              error_reg;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         dekatron_digit u_digit (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .Step  (step[gi]),
            .Dec   (digit_dec[gi]),
            .Clear (clr[gi]),
            .Pos   (Out[gi*POS_WIDTH +: POS_WIDTH]),
            .Wrap  (wrap[gi])
         );
         assign is_zero[gi] = (Out[gi*POS_WIDTH +: POS_WIDTH] == POS_ZERO);
`ifdef DEKATRON_ONEHOT_CHECK_EN
         assign bad[gi] = ($countones(Out[gi*POS_WIDTH +: POS_WIDTH]) != 1);
`endif
      end
   endgenerate

`ifdef DEKATRON_ONEHOT_CHECK_EN
   assign any_bad = |bad;
   // A corrupted digit is repaired on its own; healthy digits keep their value.
   assign clr     = {DIGITS{clear_all}} | bad;
`else
   assign clr     = {DIGITS{clear_all}};
`endif

   // Step/direction decode. Kept apart from the next-state logic because the
   // digits' Wrap outputs depend on these strobes.
   always_comb begin
      step      = '0;
      digit_dec = {DIGITS{dir_reg}};
      clear_all = 1'b0;
      case (state_reg)
         IDLE: begin
            if (Clear) begin
               clear_all = 1'b1;
            end else if (Request) begin
               step[0]      = 1'b1;
               digit_dec[0] = Dec;    // latch not yet loaded on this edge
            end
         end
         RIPPLE: begin
            step[idx_reg] = 1'b1;
         end
         default: ;
      endcase
`ifdef DEKATRON_ONEHOT_CHECK_EN
      if (any_bad) begin
         step      = '0;
         clear_all = 1'b0;
      end
`endif
   end

   // Next-state, index and carry.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      dir_next   = dir_reg;
      carry_next = wrap[DIGITS-1];   // only the stepping digit can wrap
      case (state_reg)
         IDLE: begin
            if (!Clear && Request) begin
               dir_next = Dec;
               if (DIGITS > 1 && wrap[0]) begin
                  state_next = RIPPLE;
                  idx_next   = IDX_W'(1);
               end
            end
         end
         RIPPLE: begin
            if (wrap[idx_reg] && idx_reg != LAST_IDX) begin
               idx_next = idx_reg + 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
`ifdef DEKATRON_ONEHOT_CHECK_EN
      if (any_bad) begin
         state_next = IDLE;
         dir_next   = dir_reg;
         carry_next = 1'b0;
      end
`endif
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         dir_reg   <= 1'b0;
         ready_reg <= 1'b1;
         carry_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         dir_reg   <= dir_next;
         ready_reg <= (state_next == IDLE);
         carry_reg <= carry_next;
      end
   end

`ifdef DEKATRON_ONEHOT_CHECK_EN
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         error_reg <= 1'b0;
      end else begin
         error_reg <= any_bad;
      end
   end
   assign Error = error_reg;
`endif

   assign Ready = ready_reg;
   assign Carry = carry_reg;
   assign Zero  = &is_zero;

endmodule

// File: tb/tb_dekatron_counter.sv
// tb_dekatron_counter
//   Scoreboard bench for dekatron_counter (DIGITS=4). Stimulus pushes the
//   expected decimal value, Ready and Carry for a given cycle; a monitor on
//   the falling edge pops and compares every entry due on that cycle.
//   Configuration macro: DEKATRON_ONEHOT_CHECK_EN (adds the Error checks).
module tb_dekatron_counter;

   localparam int DIGITS = 4;

   logic                 Clk = 1'b0;
   logic                 Rst_n;
   logic                 Request = 1'b0;
   logic                 Dec = 1'b0;
   logic                 Clear = 1'b0;
   logic                 Ready;
   logic [DIGITS*10-1:0] Out;
   logic                 Zero;
   logic                 Carry;
`ifdef DEKATRON_ONEHOT_CHECK_EN
   logic                 Error;
`endif

   dekatron_counter #(.DIGITS(DIGITS)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Request (Request),
      .Dec     (Dec),
      .Clear   (Clear),
      .Ready   (Ready),
      .Out     (Out),
      .Zero    (Zero),
      .Carry   (Carry)
`ifdef DEKATRON_ONEHOT_CHECK_EN
      ,
      .Error   (Error)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int    tag;
      int    value;
      bit    ready;
      bit    carry;
      string name;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic logic [DIGITS*10-1:0] to_pos(input int v);
      logic [DIGITS*10-1:0] p;
      int r;
      p = '0;
      r = v;
      for (int d = 0; d < DIGITS; d++) begin
         p[d*10 + (r % 10)] = 1'b1;
         r = r / 10;
      end
      return p;
   endfunction

   // Expect, 'offset' falling edges from now, the given counter state.
   task automatic sb_push(input int offset, input int value, input bit ready,
                          input bit carry, input string name);
      exp_t e;
      e.tag   = cyc + offset;
      e.value = value;
      e.ready = ready;
      e.carry = carry;
      e.name  = name;
      sbq.push_back(e);
   endtask

   // Monitor: count falling edges and check every entry that is due.
   initial begin
      exp_t                 e;
      logic [DIGITS*10-1:0] ep;
      logic                 ez;
      forever begin
         @(negedge Clk);
         cyc++;
         while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            e  = sbq.pop_front();
            ep = to_pos(e.value);
            ez = (e.value == 0);
            vectors++;
            if (e.tag != cyc || Out !== ep || Ready !== e.ready ||
                Zero !== ez || Carry !== e.carry) begin
               miscompares++;
               $display("FAIL %s (cycle %0d, due %0d): got out=%h ready=%b zero=%b carry=%b, want out=%h ready=%b zero=%b carry=%b",
                        e.name, cyc, e.tag, Out, Ready, Zero, Carry, ep, e.ready, ez, e.carry);
            end else begin
               $display("vec %-20s cycle %0d: value %04d ready=%b carry=%b ok",
                        e.name, cyc, e.value, e.ready, e.carry);
            end
         end
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   // Wait until every pushed expectation has been checked.
   task automatic settle();
      int g;
      g = 0;
      while (sbq.size() > 0 && g < 20) begin
         tick();
         g++;
      end
      if (sbq.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
         sbq.delete();
      end
   endtask

   // Clear, then count up n times, waiting out every ripple.
   task automatic load(input int n);
      int done;
      int guard;
      Clear   = 1'b1;
      Request = 1'b0;
      Dec     = 1'b0;
      tick();
      Clear = 1'b0;
      done  = 0;
      guard = 0;
      while (done < n && guard < 20000) begin
         if (Ready) begin
            Request = 1'b1;
            done++;
         end else begin
            Request = 1'b0;
         end
         tick();
         guard++;
      end
      Request = 1'b0;
      guard = 0;
      while (!Ready && guard < 50) begin
         tick();
         guard++;
      end
      vectors++;
      if (!Ready || done != n) begin
         miscompares++;
         $display("FAIL load_%0d: ready=%b steps=%0d, want ready=1 steps=%0d", n, Ready, done, n);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n = 1'b1;
      #1;
      Rst_n = 1'b0;
      sb_push(1, 0, 1'b1, 1'b0, "reset_held");
      tick();
      Rst_n = 1'b1;
      sb_push(1, 0, 1'b1, 1'b0, "reset_idle");
      sb_push(2, 0, 1'b1, 1'b0, "reset_idle2");
      settle();

      // 0008: three back-to-back up Requests; the third is held over the ripple.
      load(8);
      sb_push(1,  9, 1'b1, 1'b0, "up_0009");
      sb_push(2,  0, 1'b0, 1'b0, "up_wrap_busy");
      sb_push(3, 10, 1'b1, 1'b0, "up_0010");
      sb_push(4, 11, 1'b1, 1'b0, "up_0011_held");
      sb_push(5, 11, 1'b1, 1'b0, "up_0011_idle");
      Request = 1'b1;
      Dec     = 1'b0;
      repeat (4) tick();
      Request = 1'b0;
      settle();

      // 0999 +1: full ripple; Clear and a down Request during the ripple are ignored.
      load(999);
      sb_push(1,  990, 1'b0, 1'b0, "ripple_d0");
      sb_push(2,  900, 1'b0, 1'b0, "ripple_d1");
      sb_push(3,    0, 1'b0, 1'b0, "ripple_d2");
      sb_push(4, 1000, 1'b1, 1'b0, "ripple_d3_done");
      sb_push(5, 1000, 1'b1, 1'b0, "ripple_idle");
      Request = 1'b1;
      Dec     = 1'b0;
      tick();
      Request = 1'b0;
      Clear   = 1'b1;
      Dec     = 1'b1;
      tick();
      Clear   = 1'b0;
      Request = 1'b1;
      tick();
      Request = 1'b0;
      Dec     = 1'b0;
      settle();

      // 0000 -1: borrow ripples to 9999 with a single Carry pulse.
      load(0);
      sb_push(1,    9, 1'b0, 1'b0, "down_d0");
      sb_push(2,   99, 1'b0, 1'b0, "down_d1");
      sb_push(3,  999, 1'b0, 1'b0, "down_d2");
      sb_push(4, 9999, 1'b1, 1'b1, "down_carry");
      sb_push(5, 9999, 1'b1, 1'b0, "down_carry_end");
      Request = 1'b1;
      Dec     = 1'b1;
      tick();
      Request = 1'b0;
      Dec     = 1'b0;
      settle();

      // 9999 +1: overflow back to 0000 with Carry.
      sb_push(1, 9990, 1'b0, 1'b0, "ovf_d0");
      sb_push(2, 9900, 1'b0, 1'b0, "ovf_d1");
      sb_push(3, 9000, 1'b0, 1'b0, "ovf_d2");
      sb_push(4,    0, 1'b1, 1'b1, "ovf_carry");
      sb_push(5,    0, 1'b1, 1'b0, "ovf_carry_end");
      Request = 1'b1;
      tick();
      Request = 1'b0;
      settle();

      // 0010 -1: single borrow into digit 1.
      load(10);
      sb_push(1, 19, 1'b0, 1'b0, "borrow_d0");
      sb_push(2,  9, 1'b1, 1'b0, "borrow_0009");
      Request = 1'b1;
      Dec     = 1'b1;
      tick();
      Request = 1'b0;
      Dec     = 1'b0;
      settle();

      // 0999 +1 then reset mid-ripple: immediate zero, no ripple afterwards.
      load(999);
      sb_push(1, 990, 1'b0, 1'b0, "rst_pre");
      Request = 1'b1;
      tick();
      Request = 1'b0;
      @(posedge Clk);
      #2;
      Rst_n = 1'b0;
      sb_push(1, 0, 1'b1, 1'b0, "rst_async");
      tick();
      sb_push(1, 0, 1'b1, 1'b0, "rst_held");
      sb_push(2, 0, 1'b1, 1'b0, "rst_release_idle");
      Rst_n = 1'b1;
      tick();
      settle();

      // 0042 with Clear and Request together: Clear wins.
      load(42);
      sb_push(1, 0, 1'b1, 1'b0, "clear_beats_req");
      sb_push(2, 0, 1'b1, 1'b0, "clear_idle");
      Clear   = 1'b1;
      Request = 1'b1;
      tick();
      Clear   = 1'b0;
      Request = 1'b0;
      settle();

`ifdef DEKATRON_ONEHOT_CHECK_EN
      // Corrupt digit 2 of 0000; it must be repaired and Error must pulse once.
      load(0);
      force dut.g_digit[2].u_digit.pos_reg = 10'b0000000110;
      #1;
      release dut.g_digit[2].u_digit.pos_reg;
      sb_push(1, 0, 1'b1, 1'b0, "onehot_repair");
      tick();
      vectors++;
      if (Error !== 1'b1) begin
         miscompares++;
         $display("FAIL onehot_error_pulse: got %b, want 1", Error);
      end
      tick();
      vectors++;
      if (Error !== 1'b0) begin
         miscompares++;
         $display("FAIL onehot_error_end: got %b, want 0", Error);
      end
      settle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
